// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready operand and result handshakes.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready with OP1, OP2, cmd;
//        out_valid/out_ready with RES, eq_bit, ovF, div_zero (held while out_valid).
module alu_mc #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] OP1,
   input  logic [WIDTH-1:0] OP2,
   input  logic [3:0]       cmd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] RES,
   output logic             eq_bit,
   output logic             ovF,
   output logic             div_zero
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] op2_q, op2_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             eq_q, eq_d;
   logic             ov_q, ov_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0] add_r, sub_r, s_res;
   logic [SHW-1:0]   sh;
   logic             big, s_ov, s_dz, multi;

   // Single-cycle results straight from the port operands.
   always_comb begin
      add_r = OP1 + OP2;
      sub_r = OP1 + ~OP2 + ONE;
      sh    = OP2[SHW-1:0];
      big   = |OP2[WIDTH-1:SHW];
      s_res = '0;
      s_ov  = 1'b0;
      s_dz  = 1'b0;
      multi = 1'b0;
      case (cmd)
         4'h0: begin
            s_res = add_r;
            s_ov  = (OP1[WIDTH-1] == OP2[WIDTH-1]) &&
                    (add_r[WIDTH-1] != OP1[WIDTH-1]);
         end
         4'h1: begin
            s_res = sub_r;
            s_ov  = (OP1[WIDTH-1] != OP2[WIDTH-1]) &&
                    (sub_r[WIDTH-1] != OP1[WIDTH-1]);
         end
         4'h2: s_res = big ? '0 : OP1 << sh;
         4'h3: s_res = WIDTH'(OP1 > OP2);
         4'h4: s_res = big ? '0 : OP1 >> sh;
         4'h5: s_res = OP1 & OP2;
         4'h6: s_res = OP1 | OP2;
         4'h7: s_res = WIDTH'(OP1 == OP2);
         4'h8, 4'h9: multi = 1'b1;
         4'hA: begin
            if (OP2 == '0) begin
               s_res = '1;
               s_dz  = 1'b1;
            end else begin
               multi = 1'b1;
            end
         end
         4'hB: begin
            if (OP2 == '0) begin
               s_res = OP1;
               s_dz  = 1'b1;
            end else begin
               multi = 1'b1;
            end
         end
         4'hC: s_res = big ? {WIDTH{OP1[WIDTH-1]}}
                           : WIDTH'($signed(OP1) >>> sh);
         4'hD: s_res = WIDTH'($signed(OP1) < $signed(OP2));
         4'hE: s_res = OP1 ^ OP2;
         default: s_res = '0;
      endcase
   end

   // One iteration: hi:lo is product (shift-add) or remainder:quotient (restoring).
   logic [WIDTH:0]   m_sum, d_rem;
   logic [WIDTH-1:0] d_sub, step_hi, step_lo;
   logic             d_ge;

   always_comb begin
      m_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op2_q} : '0);
      d_rem = {hi_q, lo_q[WIDTH-1]};
      d_ge  = d_rem >= {1'b0, op2_q};
      d_sub = d_rem[WIDTH-1:0] - op2_q;
      if (sel_q[1]) begin
         step_hi = d_ge ? d_sub : d_rem[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], d_ge};
      end else begin
         step_hi = m_sum[WIDTH:1];
         step_lo = {m_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      op2_d   = op2_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      eq_d    = eq_q;
      ov_d    = ov_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               eq_d  = OP1 == OP2;
               sel_d = cmd[1:0];
               op2_d = OP2;
               cnt_d = '0;
               if (multi) begin
                  state_d = CALC;
                  hi_d    = '0;
                  lo_d    = OP1;
               end else begin
                  state_d = DONE;
                  res_d   = s_res;
                  ov_d    = s_ov;
                  dz_d    = s_dz;
               end
            end
         end
         CALC: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + SHW'(1);
            // Last iteration writes the result directly.
            if (cnt_q == '1) begin
               state_d = DONE;
               res_d   = sel_q[0] ? step_hi : step_lo;
               ov_d    = ~sel_q[1] & (|step_hi);
               dz_d    = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         op2_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         eq_q    <= 1'b0;
         ov_q    <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         op2_q   <= op2_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         eq_q    <= eq_d;
         ov_q    <= ov_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign RES       = res_q;
   assign eq_bit    = eq_q;
   assign ovF       = ov_q;
   assign div_zero  = dz_q;

endmodule
